// File: rtl/key_debounce_if.sv
// key_debounce_if: key level in, debounced events out.
// Ports: d_i (synchronized key level, 1 = pressed), press_o / release_o (one-cycle event pulses),
// held_o (debounced level), count_o (press pulses issued, mod 256).
// master drives the key level; slave is the debouncer.
interface key_debounce_if;
  logic       d_i;
  logic       press_o;
  logic       release_o;
  logic       held_o;
  logic [7:0] count_o;
  modport master(output d_i, input press_o, release_o, held_o, count_o);
  modport slave(input d_i, output press_o, release_o, held_o, count_o);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: accepts key transitions after DB_CYCLES stable samples, emits press/release pulses.
// Ports: clk, reset (sync, active-high), kb (key_debounce_if.slave: d_i in; press_o, release_o,
// held_o, count_o out, all registered).
// Optional auto-repeat of the press pulse while held: define KEY_DEBOUNCE_REPEAT_EN.
module key_debounce #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input logic           clk,
  input logic           reset,
  key_debounce_if.slave kb
);
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_press, acc_rel, rep_fire, press_d;
  logic          press_q, rel_q, held_q;
  logic [7:0]    count_q;
  if (DB_CYCLES < 2 || DB_CYCLES > 65535 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("key_debounce: parameter out of range");
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    acc_press = 1'b0;
    acc_rel   = 1'b0;
    case (state_q)
      RELEASED: if (kb.d_i) begin
        state_d = PRESS_CHK;
        cnt_d   = CW'(1);
      end
      PRESS_CHK: if (!kb.d_i) state_d = RELEASED;
      else if (cnt_q == LAST) begin
        state_d   = PRESSED;
        acc_press = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      PRESSED: if (!kb.d_i) begin
        state_d = RELEASE_CHK;
        cnt_d   = CW'(1);
      end
      RELEASE_CHK: if (kb.d_i) state_d = PRESSED;
      else if (cnt_q == LAST) begin
        state_d = RELEASED;
        acc_rel = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
    endcase
  end
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  logic [RW-1:0] rep_q, rep_d;
  logic          rep_nth_q, rep_nth_d;
  // rep_nth_q selects the initial delay vs. the steady period; the counter restarts after each repeat.
  assign rep_fire = state_q == PRESSED &&
                    rep_q == (rep_nth_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  always_comb begin
    rep_d     = (acc_press || acc_rel || rep_fire) ? '0 : (state_q == PRESSED) ? rep_q + 1'b1 : rep_q;
    rep_nth_d = (acc_press || acc_rel) ? 1'b0 : rep_fire ? 1'b1 : rep_nth_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      rep_q     <= '0;
      rep_nth_q <= 1'b0;
    end else begin
      rep_q     <= rep_d;
      rep_nth_q <= rep_nth_d;
    end
`else
  assign rep_fire = 1'b0;
`endif
  assign press_d = acc_press | rep_fire;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      held_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= acc_rel;
      held_q  <= state_d inside {PRESSED, RELEASE_CHK};
      count_q <= count_q + {7'd0, press_d};
    end
  assign kb.press_o   = press_q;
  assign kb.release_o = rel_q;
  assign kb.held_o    = held_q;
  assign kb.count_o   = count_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench; a run-length key model predicts every cycle's outputs.
module tb_key_debounce;
  localparam int DB = 4, RD = 10, RP = 4;
  typedef struct packed {
    logic       p;
    logic       r;
    logic       h;
    logic [7:0] c;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  key_debounce_if kb();
  key_debounce #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk),
    .reset(reset),
    .kb(kb)
  );
  exp_t       q[$];
  int         tests = 0, fails = 0, cyc_n = 0;
  logic       m_held = 1'b0;
  int         m_run = 0, m_age = 0;
  logic [7:0] m_count = '0;
  logic       cur_d = 1'b0;
  // m_run counts consecutive samples disagreeing with the debounced level; m_age counts cycles held stable.
  task automatic cyc(input logic dv, input logic rv);
    exp_t e;
    @(negedge clk);
    kb.d_i = dv;
    reset  = rv;
    cur_d  = dv;
    e      = '0;
    if (rv) begin
      m_held  = 1'b0;
      m_run   = 0;
      m_age   = 0;
      m_count = '0;
    end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
      if (m_held && m_run == 0) begin
        m_age++;
        if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) e.p = 1'b1;
      end
`endif
      m_run = (dv != m_held) ? m_run + 1 : 0;
      if (m_run == DB) begin
        m_held = !m_held;
        m_run  = 0;
        m_age  = 0;
        if (m_held) e.p = 1'b1;
        else e.r = 1'b1;
      end
      m_count = m_count + {7'd0, e.p};
    end
    e.h = m_held;
    e.c = m_count;
    q.push_back(e);
  endtask
  task automatic run(input logic dv, input int n);
    for (int i = 0; i < n; i++) cyc(dv, 1'b0);
  endtask
  always @(posedge clk) begin
    exp_t a, e;
    #1;
    cyc_n++;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {kb.press_o, kb.release_o, kb.held_o, kb.count_o};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: got press=%b release=%b held=%b count=%0d, want press=%b release=%b held=%b count=%0d",
                 cyc_n, a.p, a.r, a.h, a.c, e.p, e.r, e.h, e.c);
      end
    end
  end
  initial begin
    kb.d_i = 1'b0;
    cyc(1'b0, 1'b1);
    run(1'b0, 10);
    run(1'b1, 8);
    run(1'b0, 8);
    run(1'b1, 3);
    run(1'b0, 5);
    run(1'b1, 6);
    run(1'b0, 2);
    run(1'b1, 1);
    run(1'b0, 6);
    run(1'b1, 3);
    cyc(1'b1, 1'b1);
    run(1'b1, 8);
    run(1'b0, 6);
    run(1'b1, 36);
    run(1'b0, 6);
    for (int i = 0; i < 2; i++) begin
      run(1'b1, 1);
      run(1'b0, 1);
    end
    for (int i = 0; i < 260; i++) begin
      run(1'b1, 5);
      run(1'b0, 5);
    end
    for (int i = 0; i < 500; i++)
      if ($urandom_range(0, 24) == 0) cyc(cur_d, 1'b1);
      else run(1'(($urandom_range(0, 1))), $urandom_range(1, 7));
    run(1'b1, 40);
    run(1'b0, 6);
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
# key_debounce

Debounce and edge-event stage that sits directly downstream of the two-flop input synchronizer. It takes the already-synchronized key level and accepts a press or release only after the level has been stable for a programmable number of cycles. Each accepted transition produces a single-cycle pulse, plus a held level and a wrapping press counter for the lab's display and control logic. Optional auto-repeat re-fires the press pulse while the key stays held.

## Interface
- DB_CYCLES, default 4: consecutive identical samples required to accept a transition; legal range 2..65535.
- REPEAT_DELAY, default 20: cycles from the accepted press pulse to the first repeat pulse; must be ≥ 2. Used only with repeat enabled.
- REPEAT_PERIOD, default 8: cycles between later repeat pulses; must be ≥ 2. Used only with repeat enabled.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- d  in  1  synchronized key level, 1 = pressed; driven by the synchronizer's second flop. No further synchronization is done here.
- press  out  1  one-cycle pulse per accepted press, and per repeat when enabled.
- release  out  1  one-cycle pulse per accepted release.
- held  out  1  debounced key level.
- count  out  8  number of press pulses issued, modulo 256.

## Operation
- All outputs are registered.
- While reset is sampled high, each clock edge forces:
  - state to RELEASED;
  - the debounce counter and the repeat counter to 0;
  - press, release and held to 0;
  - count to 0.
- States:
  - RELEASED: held=0. Sampling d=1 moves to PRESS_CHK with the debounce counter set to 1.
  - PRESS_CHK: sampling d=0 returns to RELEASED (counter cleared, no pulse). Sampling d=1 with counter = DB_CYCLES-1 moves to PRESSED, registers press=1 and held=1, and increments count. Otherwise the counter increments.
  - PRESSED: held=1. Sampling d=0 moves to RELEASE_CHK with the counter set to 1.
  - RELEASE_CHK: held stays 1. Sampling d=1 returns to PRESSED (counter cleared, no pulse). Sampling d=0 with counter = DB_CYCLES-1 moves to RELEASED, registers release=1 and held=0. Otherwise the counter increments.
- press and release are high for exactly one cycle and never high in the same cycle.
- count wraps 255→0 with no flag.
- Debounce counter width is ceil(log2(DB_CYCLES)) bits, minimum 1.

## Timing
- Press latency: first d=1 sample at edge k gives press and held high after edge k+DB_CYCLES-1, provided d stays 1 at every sampled edge. Release latency is symmetric.
- A glitch of fewer than DB_CYCLES samples produces no pulse and does not change held. Each interruption restarts counting from 1 on the next opposite sample.
- d toggling every cycle never leaves the current stable state.
- Reset mid-operation:
  - The cycle after the reset edge, all outputs are 0, even if a pulse was due on that edge.
  - If d is still 1 after reset deasserts, a new press requires the full DB_CYCLES samples.
- Reset has priority over every other transition.

## Configuration
- Macro `KEY_DEBOUNCE_REPEAT_EN`.
- When defined:
  - The repeat counter is cleared on the edge that issues the initial press. It increments on each edge spent in PRESSED and holds its value in RELEASE_CHK.
  - With the initial press pulse in cycle P, the first repeat press occurs in cycle P+REPEAT_DELAY, then every REPEAT_PERIOD cycles for as long as the state is PRESSED.
  - Each repeat pulse increments count.
  - A release pulse clears the repeat counter.
  - Time spent in RELEASE_CHK before bouncing back to PRESSED delays the next repeat by that number of cycles.
- When undefined: the repeat counter and its logic are absent, and press fires only once per accepted press.

## Test plan
All scenarios use DB_CYCLES=4. Scenarios 5 and 6 also use REPEAT_DELAY=10 and REPEAT_PERIOD=4.
1. Reset for 1 cycle, hold d=0 for 10 cycles → press, release, held and count stay 0 throughout.
2. d=1 from edge 0 and held → press high for exactly one cycle after edge 3; held=1 from then on; count=1.
3. d=1 for 3 edges then d=0 → no press pulse, held=0, count=0. Then d=1 for 4 edges → exactly one press pulse.
4. Key pressed, then d=0 for 2 edges, d=1, then d=0 for 4 edges → no release until the 4th consecutive 0; release pulse after that edge; held=0.
5. Key pressed and reset asserted on the edge where press would fire → press never seen high; after reset deasserts with d=1, press occurs 4 edges later.
6. (`KEY_DEBOUNCE_REPEAT_EN` defined) hold d=1 for 30 cycles after the press pulse in cycle P → presses in cycles P, P+10, P+14, P+18, P+22, P+26 and P+30; count=7. Without the macro, count=1.
